// File: rtl/bram_mailbox_engine_pkg.sv
// mailbox_pkg: shared state encoding, status word layout and default BRAM addresses for the mailbox engine.
package mailbox_pkg;
  typedef enum logic [2:0] {IDLE, RD_HDR, RD_DATA, WR_SUM, WR_XOR, WR_STAT, IRQ} state_e;
  localparam int ST_VALID = 31;
  localparam int ST_LENERR = 30;
  localparam int ST_OVR = 29;
  localparam int ST_SEQ_LSB = 16;
  localparam logic [10:0] DEF_REQ_BASE = 11'h000;
  localparam logic [10:0] DEF_RESP_BASE = 11'h7F0;
  function automatic logic [31:0] mk_status(input logic len_err, input logic ovr, input logic [7:0] seq,
                                            input logic [15:0] len);
    logic [31:0] s;
    s = {16'h0, len};
    s[ST_VALID] = 1'b1;
    s[ST_LENERR] = len_err;
    s[ST_OVR] = ovr;
    s[ST_SEQ_LSB +: 8] = seq;
    return s;
  endfunction
endpackage

// File: rtl/bram_mailbox_engine_if.sv
// bram_mailbox_engine_if: BRAM port B bundle; master drives the port, slave is the memory side.
interface bram_mailbox_engine_if #(parameter int ADDR_W = 11);
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       din;
  logic [31:0]       dout;
  modport master (output en, we, addr, din, input dout);
  modport slave (input en, we, addr, din, output dout);
endinterface

// File: rtl/bram_mailbox_engine_doorbell_sync.sv
// mailbox_doorbell_sync: 2-FF synchroniser for the PS doorbell plus a one-cycle rising-edge pulse.
module mailbox_doorbell_sync (
  input  logic clk,
  input  logic rst,
  input  logic doorbell_i,
  output logic pulse_o
);
  logic [2:0] sync_q;
  always_ff @(posedge clk) sync_q <= rst ? 3'b000 : {sync_q[1:0], doorbell_i};
  assign pulse_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/bram_mailbox_engine.sv
// bram_mailbox_engine: doorbell-driven BRAM request processor (sum/xor/status response, irq pulse).
// irq rises N+5+2*RD_LAT cycles after the sync pulse (5+RD_LAT when N=0); busy spans accept..irq cycle.
module bram_mailbox_engine
  import mailbox_pkg::*;
#(
  parameter int                ADDR_W    = 11,
  parameter logic [ADDR_W-1:0] REQ_BASE  = ADDR_W'(DEF_REQ_BASE),
  parameter logic [ADDR_W-1:0] RESP_BASE = ADDR_W'(DEF_RESP_BASE),
  parameter int                MAX_LEN   = 1024,
  parameter int                RD_LAT    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        doorbell_i,
  bram_mailbox_engine_if.master       bram,
  output logic                        irq_o,
  output logic                        busy_o,
  output logic                        done_led_o
);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);
  state_e            state_q, state_d;
  logic              en_q, en_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d, sum_q, sum_d, x_q, x_d;
  logic              irq_q, irq_d, busy_q, busy_d, done_q, done_d;
  logic              ovr_q, ovr_d, lenerr_q, lenerr_d;
  logic [7:0]        seq_q, seq_d;
  logic [15:0]       len_q, len_d, cnt_q, cnt_d, rcv_q, rcv_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic              pulse, dv;
  logic [15:0]       len_req, len_clip;
  mailbox_doorbell_sync u_sync (.clk(clk), .rst(rst), .doorbell_i(doorbell_i), .pulse_o(pulse));
  assign dv = vld_q[RD_LAT-1];
  assign len_req = bram.dout[15:0];
  assign len_clip = len_req > MAX_L ? MAX_L : len_req;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      en_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      din_q <= '0;
      irq_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      seq_q <= '0;
      ovr_q <= 1'b0;
      lenerr_q <= 1'b0;
      len_q <= '0;
      cnt_q <= '0;
      rcv_q <= '0;
      sum_q <= '0;
      x_q <= '0;
      vld_q <= '0;
    end else begin
      state_q <= state_d;
      en_q <= en_d;
      we_q <= we_d;
      addr_q <= addr_d;
      din_q <= din_d;
      irq_q <= irq_d;
      busy_q <= busy_d;
      done_q <= done_d;
      seq_q <= seq_d;
      ovr_q <= ovr_d;
      lenerr_q <= lenerr_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      rcv_q <= rcv_d;
      sum_q <= sum_d;
      x_q <= x_d;
      vld_q <= vld_d;
    end
  end
  always_comb begin
    state_d = state_q;
    en_d = 1'b0;
    we_d = 1'b0;
    addr_d = addr_q;
    din_d = din_q;
    irq_d = 1'b0;
    busy_d = busy_q;
    done_d = done_q;
    seq_d = seq_q;
    ovr_d = ovr_q | (pulse & busy_q);
    lenerr_d = lenerr_q;
    len_d = len_q;
    cnt_d = cnt_q;
    rcv_d = rcv_q;
    sum_d = sum_q;
    x_d = x_q;
    vld_d = RD_LAT'({vld_q, en_q & ~we_q});
    case (state_q)
      IDLE: if (pulse) begin
        state_d = RD_HDR;
        busy_d = 1'b1;
        done_d = 1'b0;
        en_d = 1'b1;
        addr_d = REQ_BASE;
        sum_d = '0;
        x_d = '0;
      end
      RD_HDR: if (dv) begin
        len_d = len_clip;
        lenerr_d = len_req > MAX_L;
        en_d = 1'b1;
        we_d = len_clip == 16'd0;
        state_d = len_clip == 16'd0 ? WR_SUM : RD_DATA;
        addr_d = len_clip == 16'd0 ? RESP_BASE : REQ_BASE + ADDR_W'(1);
        din_d = len_clip == 16'd0 ? 32'd0 : din_q;
        cnt_d = 16'd1;
        rcv_d = 16'd0;
      end
      RD_DATA: begin
        if (cnt_q != len_q) begin
          en_d = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          cnt_d = cnt_q + 16'd1;
        end
        if (dv) begin
          sum_d = sum_q + bram.dout;
          x_d = x_q ^ bram.dout;
          rcv_d = rcv_q + 16'd1;
          if (rcv_q + 16'd1 == len_q) begin
            state_d = WR_SUM;
            en_d = 1'b1;
            we_d = 1'b1;
            addr_d = RESP_BASE;
            din_d = sum_d;
          end
        end
      end
      WR_SUM: begin
        state_d = WR_XOR;
        en_d = 1'b1;
        we_d = 1'b1;
        addr_d = RESP_BASE + ADDR_W'(1);
        din_d = x_q;
      end
      WR_XOR: begin
        // An edge landing now still belongs to this status; later edges roll into the next one
        state_d = WR_STAT;
        en_d = 1'b1;
        we_d = 1'b1;
        addr_d = RESP_BASE + ADDR_W'(2);
        din_d = mk_status(lenerr_q, ovr_q | pulse, seq_q, len_q);
        ovr_d = 1'b0;
      end
      WR_STAT: begin
        state_d = IRQ;
        irq_d = 1'b1;
        done_d = 1'b1;
      end
      IRQ: begin
        state_d = IDLE;
        busy_d = 1'b0;
        seq_d = seq_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bram.en = en_q;
  assign bram.we = we_q;
  assign bram.addr = addr_q;
  assign bram.din = din_q;
  assign irq_o = irq_q;
  assign busy_o = busy_q;
  assign done_led_o = done_q;
endmodule

// File: tb/tb_bram_mailbox_engine.sv
// tb_bram_mailbox_engine: runs RD_LAT=1 and RD_LAT=2 engines side by side against a transaction-level model.
module tb_bram_mailbox_engine;
  localparam logic [10:0] REQ = 11'h000;
  localparam logic [10:0] RESP = 11'h7F0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic doorbell = 1'b0;
  always #5 clk = ~clk;
  bram_mailbox_engine_if #(.ADDR_W(11)) bif0 ();
  bram_mailbox_engine_if #(.ADDR_W(11)) bif1 ();
  logic irq_w[2], busy_w[2], done_w[2], en_w[2], we_w[2];
  logic [10:0] addr_w[2];
  logic [31:0] din_w[2], dout_r[2], p1;
  bram_mailbox_engine #(.RD_LAT(1)) dut0 (.clk(clk), .rst(rst), .doorbell_i(doorbell), .bram(bif0.master),
    .irq_o(irq_w[0]), .busy_o(busy_w[0]), .done_led_o(done_w[0]));
  bram_mailbox_engine #(.RD_LAT(2)) dut1 (.clk(clk), .rst(rst), .doorbell_i(doorbell), .bram(bif1.master),
    .irq_o(irq_w[1]), .busy_o(busy_w[1]), .done_led_o(done_w[1]));
  assign en_w[0] = bif0.en;
  assign en_w[1] = bif1.en;
  assign we_w[0] = bif0.we;
  assign we_w[1] = bif1.we;
  assign addr_w[0] = bif0.addr;
  assign addr_w[1] = bif1.addr;
  assign din_w[0] = bif0.din;
  assign din_w[1] = bif1.din;
  assign bif0.dout = dout_r[0];
  assign bif1.dout = dout_r[1];
  logic [31:0] mem [2048];
  always @(posedge clk) begin
    if (en_w[0] && !we_w[0]) dout_r[0] <= mem[addr_w[0]];
    if (en_w[1] && !we_w[1]) p1 <= mem[addr_w[1]];
    dout_r[1] <= p1;
  end
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, fails = 0, t0 = 0;
  int irq_cnt[2] = '{0, 0};
  int e_len = 0, e_lat[2];
  logic e_err = 1'b0, e_ovr = 1'b0;
  logic [31:0] e_sum, e_x;
  logic [7:0] e_seq[2] = '{8'd0, 8'd0};
  logic [10:0] wa[2][$];
  logic [31:0] wd[2][$];
  logic [31:0] last_w[2][3];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    for (int i = 0; i < 2; i++) begin
      if (we_w[i]) begin
        chk("we_has_en", 32'(en_w[i]), 32'd1);
        chk("wr_in_resp", 32'(addr_w[i] >= RESP && addr_w[i] <= RESP + 11'd2), 32'd1);
        wa[i].push_back(addr_w[i]);
        wd[i].push_back(din_w[i]);
      end else if (en_w[i]) chk("rd_in_req", 32'(addr_w[i] <= REQ + 11'(e_len)), 32'd1);
      if (irq_w[i]) begin
        irq_cnt[i]++;
        chk("irq_busy_done", 32'({busy_w[i], done_w[i]}), 32'd3);
        chk("irq_latency", 32'(cyc - t0), 32'(e_lat[i]));
        chk("n_writes", 32'(wd[i].size()), 32'd3);
        if (wd[i].size() == 3) for (int k = 0; k < 3; k++) begin
          chk("resp_addr", 32'(wa[i][k]), 32'(RESP) + 32'(k));
          chk("resp_word", wd[i][k], k == 0 ? e_sum : k == 1 ? e_x :
              32'h8000_0000 | (32'(e_err) << 30) | (32'(e_ovr) << 29) | (32'(e_seq[i]) << 16) | 32'(e_len));
          last_w[i][k] = wd[i][k];
        end
        wa[i].delete();
        wd[i].delete();
        e_seq[i]++;
      end
    end
  end
  task automatic setup(input int hdr);
    mem[REQ] = {16'($urandom), 16'(hdr)};
    e_len = hdr > 1024 ? 1024 : hdr;
    e_err = hdr > 1024;
    e_sum = 0;
    e_x = 0;
    for (int k = 1; k <= e_len; k++) begin
      e_sum += mem[REQ + 11'(k)];
      e_x ^= mem[REQ + 11'(k)];
    end
    for (int i = 0; i < 2; i++) e_lat[i] = e_len == 0 ? 8 + i : e_len + 9 + 2 * i;
  endtask
  task automatic fill_rand(input int n);
    for (int k = 1; k <= n; k++) mem[REQ + 11'(k)] = $urandom;
  endtask
  task automatic chk_reset_outs();
    for (int i = 0; i < 2; i++) begin
      chk("rst_ctl", 32'({en_w[i], we_w[i], irq_w[i], busy_w[i], done_w[i]}), 32'd0);
      chk("rst_addr", 32'(addr_w[i]), 32'd0);
      chk("rst_din", din_w[i], 32'd0);
    end
  endtask
  task automatic run_txn(input int hdr, input bit toggle, input bit hold);
    int b[2];
    bit got;
    setup(hdr);
    e_ovr = toggle;
    b[0] = irq_cnt[0];
    b[1] = irq_cnt[1];
    got = 0;
    @(negedge clk);
    doorbell = 1'b1;
    t0 = cyc;
    for (int k = 0; k < e_len + 60; k++) begin
      @(negedge clk);
      if (k == 3 && !hold) doorbell = 1'b0;
      if (toggle && k == 20) doorbell = 1'b1;
      if (toggle && k == 24) doorbell = 1'b0;
      if (k == 5) for (int i = 0; i < 2; i++) chk("busy_on_done_off", 32'({busy_w[i], done_w[i]}), 32'd2);
      if (irq_cnt[0] > b[0] && irq_cnt[1] > b[1]) begin
        got = 1;
        break;
      end
    end
    chk("irq_seen", 32'(got), 32'd1);
    if (hold) repeat (10000) @(negedge clk);
    doorbell = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("irq_once", 32'(irq_cnt[i] - b[i]), 32'd1);
      chk("idle_busy_done", 32'({busy_w[i], done_w[i]}), 32'd1);
    end
  endtask
  initial begin
    logic [31:0] lit[3];
    logic [31:0] st;
    for (int k = 0; k < 2048; k++) mem[k] = 32'h0;
    repeat (4) @(negedge clk);
    chk_reset_outs();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 1; k <= 4; k++) mem[REQ + 11'(k)] = 32'(k);
    run_txn(4, 0, 0);
    lit = '{32'h0000_000A, 32'h0000_0004, 32'h8000_0004};
    for (int i = 0; i < 2; i++) for (int k = 0; k < 3; k++) chk("basic_lit", last_w[i][k], lit[k]);
    run_txn(0, 0, 0);
    for (int i = 0; i < 2; i++) chk("zero_len_stat", last_w[i][2], 32'h8001_0000);
    for (int k = 1; k <= 1100; k++) mem[REQ + 11'(k)] = 32'hFFFF_FFFF;
    run_txn(2000, 0, 0);
    lit = '{32'hFFFF_FC00, 32'h0000_0000, 32'hC002_0400};
    for (int i = 0; i < 2; i++) for (int k = 0; k < 3; k++) chk("clip_lit", last_w[i][k], lit[k]);
    fill_rand(64);
    run_txn(64, 1, 0);
    st = last_w[0][2];
    chk("ovr_bit", 32'({st[29], st[23:16]}), 32'h103);
    fill_rand(16);
    run_txn(16, 0, 0);
    st = last_w[0][2];
    chk("ovr_clear", 32'({st[29], st[23:16]}), 32'h004);
    fill_rand(64);
    setup(64);
    @(negedge clk);
    doorbell = 1'b1;
    repeat (4) @(negedge clk);
    doorbell = 1'b0;
    repeat (16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) e_seq[i] = 8'd0;
    st = 32'(irq_cnt[0] + irq_cnt[1]);
    repeat (50) @(negedge clk);
    chk("abort_no_irq", 32'(irq_cnt[0] + irq_cnt[1]), st);
    chk("abort_no_write", 32'(wd[0].size() + wd[1].size()), 32'd0);
    fill_rand(10);
    run_txn(10, 0, 0);
    run_txn($urandom_range(1, 30), 0, 0);
    st = last_w[1][2];
    chk("seq_after_abort", 32'(st[23:16]), 32'd1);
    fill_rand(8);
    run_txn(8, 0, 1);
    for (int r = 0; r < 4; r++) begin
      fill_rand(40);
      run_txn($urandom_range(0, 40), 0, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/bram_mailbox_engine.md
Name: bram_mailbox_engine

Overview:
- PL-side consumer of shared BRAM port B; replaces the fixed counter-fill logic feeding that port.
- PS writes a request block into BRAM, then raises doorbell (PS-to-PL GPIO bit).
- Engine reads header and payload, computes a 32-bit wrap-around sum and an XOR of the payload, writes a 3-word response, then pulses the PL-to-PS interrupt.

Parameters:
- ADDR_W, 11, BRAM port B word-address width (2K x 32).
- REQ_BASE, 11'h000, word address of request header; payload starts at REQ_BASE+1.
- RESP_BASE, 11'h7F0, word address of response block (sum, xor, status).
- MAX_LEN, 1024, maximum payload words processed; must satisfy REQ_BASE+MAX_LEN < RESP_BASE.
- RD_LAT, 1, BRAM port B read latency in cycles (1 or 2).

Ports:
- clk  in  1  clock, same domain as BRAM port B.
- rst  in  1  reset, synchronous, active-high.
- doorbell  in  1  PS GPIO bit, asynchronous to clk.
- bram_en  out  1  port B enable.
- bram_we  out  1  port B write enable.
- bram_addr  out  ADDR_W  port B word address.
- bram_din  out  32  port B write data.
- bram_dout  in  32  port B read data, valid RD_LAT cycles after address issue with bram_en=1.
- irq  out  1  one-cycle interrupt pulse to PS.
- busy  out  1  high from doorbell accept until irq cycle inclusive.
- done_led  out  1  high from irq until the next accepted doorbell.

Behaviour:
- Reset values: bram_en=0, bram_we=0, bram_addr=0, bram_din=0, irq=0, busy=0, done_led=0, seq=0, overrun=0, state=IDLE. Reset mid-transaction aborts it with no further BRAM write and no irq.
- doorbell passes through a 2-FF synchroniser. The trigger is the rising edge of the synchronised signal (third register). A level held high never retriggers.
- IDLE: on edge, set busy, go to RD_HDR.
- RD_HDR: issue read of REQ_BASE, wait RD_LAT cycles.
  - len_req = bram_dout[15:0].
  - len = min(len_req, MAX_LEN).
  - len_err = (len_req > MAX_LEN).
- RD_DATA: issue addresses REQ_BASE+1 .. REQ_BASE+len, one per cycle, back-to-back.
  - A valid shift register of depth RD_LAT tags returning data.
  - Each returned word: sum <= sum + word (mod 2^32); x <= x ^ word.
  - Leave once all len words have returned.
  - len=0 skips straight to WR_SUM with sum=0, x=0.
- WR_SUM, WR_XOR, WR_STAT: write RESP_BASE, +1, +2 on consecutive cycles, bram_we=1 for exactly those 3 cycles.
- Status word layout:
  - [31] = 1 (valid marker).
  - [30] = len_err.
  - [29] = overrun.
  - [23:16] = seq.
  - [15:0] = len (words actually processed).
- IRQ: irq=1 for one cycle; busy drops the same cycle; done_led=1; seq increments (wraps 255 -> 0); overrun clears. Then return to IDLE.
- Doorbell edge while busy: ignored, but sets overrun. That overrun is reported in the current transaction's status if WR_STAT has not yet occurred, otherwise in the next one.
- An accepted doorbell clears done_led the cycle after the edge.
- bram_en=1 only while reading or writing; bram_we never asserts during reads.
- Latency, len=N, RD_LAT=1: edge (sync output) to irq = 1 + 2 + N + 1 + 3 + 1 cycles, about N+8 ± 1. The exact count is fixed by the implementation and documented in the RTL header; the bench checks it.

Decomposition:
- Package mailbox_pkg holds:
  - state enum (IDLE, RD_HDR, RD_DATA, WR_SUM, WR_XOR, WR_STAT, IRQ);
  - status bit positions (ST_VALID=31, ST_LENERR=30, ST_OVR=29, ST_SEQ_LSB=16);
  - default REQ_BASE and RESP_BASE.
- One natural sub-module, mailbox_doorbell_sync: 2-FF synchroniser plus rising-edge detector. Its output is a single-cycle pulse; its reset is synchronous.

Test Plan:
- Payload 4 words [1,2,3,4], header 4, doorbell rise ->
  - RESP_BASE = 0x0000000A;
  - +1 = 0x00000004;
  - +2 = 0x80000004;
  - exactly one irq pulse; done_led=1.
- Header 0 -> sum 0, xor 0, status 0x80000000 | seq<<16; irq fires; no payload reads observed.
- Header 2000 with MAX_LEN=1024, payload all 0xFFFFFFFF ->
  - sum 0xFFFFFC00;
  - xor 0;
  - status bit30=1 and [15:0]=1024;
  - no read above address REQ_BASE+1024.
- Second doorbell toggled during a 64-word transaction -> that status has bit29=1; no second irq; a following clean doorbell gives bit29=0 and seq advanced by 2 total.
- rst asserted mid RD_DATA -> all outputs return to reset values next cycle; no write to RESP_BASE region; no irq; next doorbell completes normally with seq=1.
- Doorbell held high for 10k cycles after one transaction -> exactly one irq. Repeat the first scenario with RD_LAT=2 -> identical response words.
